mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 148 ++++++++++++++
 tb/tb_mem_stage.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory stage: holds one instruction, waits for the data response, then forms load results.
// Optional lwl/lwr merge support is enabled by defining MS_LWLR_EN.
module mem_stage (
  input  logic         clk,
  input  logic         reset,
  output logic         ms_allowin,
  input  logic         es_to_ms_valid,
  input  logic [135:0] es_to_ms_bus,
  output logic         ms_to_ws_valid,
  output logic [127:0] ms_to_ws_bus,
  input  logic         ws_allowin,
  input  logic         data_sram_data_ok,
  input  logic [31:0]  data_sram_rdata,
  input  logic         flush,
  output logic [4:0]   ms_rf_dest,
  output logic         ms_fwd_valid,
  output logic [31:0]  ms_fwd_data,
  output logic         ms_ex_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic         ms_valid_q, ms_valid_d;
  logic [1:0]   state_q, state_d;
  logic [1:0]   discard_q, discard_d;
  logic [131:0] bus_q, bus_d;
  logic [31:0]  rdata_buf_q, rdata_buf_d;

  logic         unused_reserved;
  assign unused_reserved = ^es_to_ms_bus[131:128];

  // Stored bus: {mem_req, load_op, passthrough[127:0]}; reserved bits are dropped.
  logic        mem_req, ex, is_load, store_op;
  logic [2:0]  load_op;
  logic [31:0] final_result, raw, res;
  logic [3:0]  strb;
  logic [1:0]  a;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        data_ok_eff, ms_ready_go, handoff, accept;

  assign mem_req      = bus_q[131];
  assign load_op      = bus_q[130:128];
  assign ex           = bus_q[78];
  assign final_result = bus_q[63:32];
  assign a            = final_result[1:0];
  assign is_load      = mem_req && !ex && (load_op != 3'd7);
  assign store_op     = mem_req && (load_op == 3'd7);

  // Responses still owed to flushed requests are swallowed until the counter drains.
  assign data_ok_eff  = data_sram_data_ok && (discard_q == 2'd0);
  assign ms_ready_go  = (state_q == S_DONE) || ((state_q == S_WAIT) && data_ok_eff);
  assign ms_allowin   = !ms_valid_q || (ms_ready_go && ws_allowin);
  assign ms_to_ws_valid = ms_valid_q && ms_ready_go;
  assign handoff      = ms_to_ws_valid && ws_allowin;
  assign accept       = es_to_ms_valid && ms_allowin && !flush;

  // The response cycle bypasses the buffer so WB gets the load with no extra latency.
  assign raw = (state_q == S_WAIT) ? data_sram_rdata : rdata_buf_q;

  always_comb begin
    byte_sel = raw[7:0];
    case (a)
      2'd0: byte_sel = raw[7:0];
      2'd1: byte_sel = raw[15:8];
      2'd2: byte_sel = raw[23:16];
      2'd3: byte_sel = raw[31:24];
      default: byte_sel = raw[7:0];
    endcase
    half_sel = a[1] ? raw[31:16] : raw[15:0];
    res  = final_result;
    strb = bus_q[72:69];
    if (is_load) begin
      case (load_op)
        3'd0: begin res = raw; strb = 4'b1111; end
        3'd1: begin res = {{24{byte_sel[7]}}, byte_sel}; strb = 4'b1111; end
        3'd2: begin res = {24'd0, byte_sel}; strb = 4'b1111; end
        3'd3: begin res = {{16{half_sel[15]}}, half_sel}; strb = 4'b1111; end
        3'd4: begin res = {16'd0, half_sel}; strb = 4'b1111; end
`ifdef MS_LWLR_EN
        3'd5: begin res = raw << {~a, 3'b000}; strb = 4'b1111 << ~a; end
        3'd6: begin res = raw >> {a, 3'b000}; strb = 4'b1111 >> a; end
`else
        3'd5, 3'd6: begin res = raw; strb = 4'b1111; end
`endif
        default: begin end
      endcase
    end
  end

  always_comb begin
    ms_valid_d  = ms_valid_q;
    state_d     = state_q;
    bus_d       = bus_q;
    rdata_buf_d = rdata_buf_q;
    discard_d   = discard_q;
    if ((state_q == S_WAIT) && data_ok_eff) begin
      rdata_buf_d = data_sram_rdata;
      state_d     = S_DONE;
    end
    if (handoff) begin
      ms_valid_d = 1'b0;
      state_d    = S_IDLE;
    end
    if (accept) begin
      ms_valid_d = 1'b1;
      bus_d      = {es_to_ms_bus[135:132], es_to_ms_bus[127:0]};
      state_d    = (es_to_ms_bus[135] && !es_to_ms_bus[78]) ? S_WAIT : S_DONE;
    end
    if (flush) begin
      ms_valid_d = 1'b0;
      state_d    = S_IDLE;
    end
    // A flush with a response in the same cycle leaves the outstanding count unchanged.
    if (flush && (state_q == S_WAIT)) begin
      if (!data_sram_data_ok && (discard_q != 2'd3))
        discard_d = discard_q + 2'd1;
    end else if (data_sram_data_ok && (discard_q != 2'd0)) begin
      discard_d = discard_q - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid_q <= 1'b0;
      state_q    <= S_IDLE;
      discard_q  <= 2'd0;
    end else begin
      ms_valid_q <= ms_valid_d;
      state_q    <= state_d;
      discard_q  <= discard_d;
    end
  end

  always_ff @(posedge clk) begin
    bus_q       <= bus_d;
    rdata_buf_q <= rdata_buf_d;
  end

  assign ms_to_ws_bus = ms_valid_q ? {bus_q[127:73], strb, bus_q[68:64], res, bus_q[31:0]} : 128'd0;
  assign ms_fwd_valid = ms_valid_q && (state_q == S_DONE);
  assign ms_fwd_data  = ms_valid_q ? res : 32'd0;
  assign ms_rf_dest   = (ms_valid_q && !ex && !store_op) ? bus_q[68:64] : 5'd0;
  assign ms_ex_o      = ms_valid_q && ex;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: table-driven loads plus stall, flush, exception and reset sequences.
module tb_mem_stage;

  logic         clk = 1'b0;
  logic         reset;
  logic         ms_allowin;
  logic         es_to_ms_valid;
  logic [135:0] es_to_ms_bus;
  logic         ms_to_ws_valid;
  logic [127:0] ms_to_ws_bus;
  logic         ws_allowin;
  logic         data_sram_data_ok;
  logic [31:0]  data_sram_rdata;
  logic         flush;
  logic [4:0]   ms_rf_dest;
  logic         ms_fwd_valid;
  logic [31:0]  ms_fwd_data;
  logic         ms_ex_o;

  int errors = 0;
  int checks = 0;
  logic [127:0] exp_q[$];
  logic [4:0]   last_dest;

  mem_stage dut (
    .clk(clk), .reset(reset), .ms_allowin(ms_allowin),
    .es_to_ms_valid(es_to_ms_valid), .es_to_ms_bus(es_to_ms_bus),
    .ms_to_ws_valid(ms_to_ws_valid), .ms_to_ws_bus(ms_to_ws_bus),
    .ws_allowin(ws_allowin), .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata), .flush(flush),
    .ms_rf_dest(ms_rf_dest), .ms_fwd_valid(ms_fwd_valid),
    .ms_fwd_data(ms_fwd_data), .ms_ex_o(ms_ex_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic        mem_req;
    logic [31:0] addr;
    logic [3:0]  in_strb;
    logic [31:0] rdata;
    logic [31:0] exp_res;
    logic [3:0]  exp_strb;
  } vec_t;

  vec_t vecs[10];

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Every handoff to WB is checked against the oldest expected bus.
  always @(negedge clk) begin
    if (!reset && ms_to_ws_valid && ws_allowin) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_handoff: got %h expected none", ms_to_ws_bus);
      end else begin
        checkOutput("wb_bus", ms_to_ws_bus, exp_q.pop_front());
      end
    end
  end

  task automatic applyStimulus(input logic [135:0] bus);
    int n = 0;
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = bus;
    while (!ms_allowin && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!ms_allowin) checkOutput("allowin_timeout", 128'd0, 128'd1);
    @(posedge clk); #1;
    es_to_ms_valid = 1'b0;
  endtask

  task automatic sendInstr(input logic [2:0] op, input logic mem_req, input logic ex,
                           input logic [31:0] addr, input logic [3:0] in_strb,
                           input logic [31:0] exp_res, input logic [3:0] exp_strb, input bit push);
    logic [48:0]  hi;
    logic [4:0]   lo5;
    logic [31:0]  pc;
    hi = {$urandom, $urandom};
    lo5 = 5'($urandom);
    pc = $urandom;
    last_dest = 5'($urandom_range(1, 31));
    if (push) exp_q.push_back({hi, ex, lo5, exp_strb, last_dest, exp_res, pc});
    applyStimulus({mem_req, op, 4'hA, hi, ex, lo5, in_strb, last_dest, addr, pc});
  endtask

  task automatic respond(input logic [31:0] rdata);
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = rdata;
    @(posedge clk); #1;
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'd0;
  endtask

  task automatic waitDrain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      checkOutput(name, 128'(exp_q.size()), 128'd0);
      exp_q.delete();
    end
  endtask

  initial begin
    vecs[0] = '{3'd1, 1'b1, 32'h0000_1003, 4'b1111, 32'h80FF_1234, 32'hFFFF_FF80, 4'b1111};
    vecs[1] = '{3'd2, 1'b1, 32'h0000_1002, 4'b1111, 32'h80FF_1234, 32'h0000_00FF, 4'b1111};
    vecs[2] = '{3'd3, 1'b1, 32'h0000_2002, 4'b1111, 32'h80FF_1234, 32'hFFFF_80FF, 4'b1111};
    vecs[3] = '{3'd4, 1'b1, 32'h0000_2000, 4'b1111, 32'h80FF_9234, 32'h0000_9234, 4'b1111};
    vecs[4] = '{3'd0, 1'b1, 32'h0000_3000, 4'b1111, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'b1111};
`ifdef MS_LWLR_EN
    vecs[5] = '{3'd5, 1'b1, 32'h0000_4001, 4'b1111, 32'h1122_3344, 32'h3344_0000, 4'b1100};
    vecs[6] = '{3'd6, 1'b1, 32'h0000_4002, 4'b1111, 32'h1122_3344, 32'h0000_1122, 4'b0011};
`else
    vecs[5] = '{3'd5, 1'b1, 32'h0000_4001, 4'b1111, 32'h1122_3344, 32'h1122_3344, 4'b1111};
    vecs[6] = '{3'd6, 1'b1, 32'h0000_4002, 4'b1111, 32'h1122_3344, 32'h1122_3344, 4'b1111};
`endif
    vecs[7] = '{3'd7, 1'b0, 32'h1234_5678, 4'b1111, 32'h0,         32'h1234_5678, 4'b1111};
    vecs[8] = '{3'd7, 1'b1, 32'h0000_5004, 4'b0110, 32'h0,         32'h0000_5004, 4'b0110};
    vecs[9] = '{3'd1, 1'b1, 32'h0000_6000, 4'b1111, 32'h0000_007F, 32'h0000_007F, 4'b1111};

    reset = 1'b1; es_to_ms_valid = 1'b0; es_to_ms_bus = '0; ws_allowin = 1'b1;
    data_sram_data_ok = 1'b0; data_sram_rdata = '0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_allowin", 128'(ms_allowin), 128'd1);
    checkOutput("reset_ws_valid", 128'(ms_to_ws_valid), 128'd0);
    checkOutput("reset_fwd_valid", 128'(ms_fwd_valid), 128'd0);
    checkOutput("reset_ex_o", 128'(ms_ex_o), 128'd0);
    checkOutput("reset_rf_dest", 128'(ms_rf_dest), 128'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      sendInstr(vecs[i].op, vecs[i].mem_req, 1'b0, vecs[i].addr, vecs[i].in_strb,
                vecs[i].exp_res, vecs[i].exp_strb, 1'b1);
      checkOutput($sformatf("rf_dest_%0d", i), 128'(ms_rf_dest),
                  128'((vecs[i].mem_req && vecs[i].op == 3'd7) ? 5'd0 : last_dest));
      if (vecs[i].mem_req) begin
        checkOutput($sformatf("wait_hold_%0d", i), 128'(ms_to_ws_valid), 128'd0);
        respond(vecs[i].rdata);
      end
      waitDrain($sformatf("drain_%0d", i));
    end

    // Response arrives while WB is stalled; the buffered word must survive.
    ws_allowin = 1'b0;
    sendInstr(3'd0, 1'b1, 1'b0, 32'h0000_0100, 4'b1111, 32'hDEAD_BEEF, 4'b1111, 1'b1);
    respond(32'hDEAD_BEEF);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("stall_fwd_valid", 128'(ms_fwd_valid), 128'd1);
    checkOutput("stall_fwd_data", 128'(ms_fwd_data), 128'hDEAD_BEEF);
    checkOutput("stall_pending", 128'(exp_q.size()), 128'd1);
    ws_allowin = 1'b1;
    waitDrain("stall_drain");

    // Flush in WAIT: the stale response is discarded, the next completes the new load.
    sendInstr(3'd0, 1'b1, 1'b0, 32'h0000_0200, 4'b1111, 32'h0, 4'b1111, 1'b0);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checkOutput("flush_ws_valid", 128'(ms_to_ws_valid), 128'd0);
    checkOutput("flush_allowin", 128'(ms_allowin), 128'd1);
    sendInstr(3'd0, 1'b1, 1'b0, 32'h0000_0204, 4'b1111, 32'hCAFE_F00D, 4'b1111, 1'b1);
    respond(32'h1111_1111);
    checkOutput("flush_discard_pending", 128'(exp_q.size()), 128'd1);
    checkOutput("flush_discard_fwd", 128'(ms_fwd_valid), 128'd0);
    respond(32'hCAFE_F00D);
    waitDrain("flush_drain");

    // Excepting load never waits even though a request was flagged.
    sendInstr(3'd0, 1'b1, 1'b1, 32'h0000_0300, 4'b1111, 32'h0000_0300, 4'b1111, 1'b1);
    checkOutput("ex_ex_o", 128'(ms_ex_o), 128'd1);
    checkOutput("ex_ws_valid", 128'(ms_to_ws_valid), 128'd1);
    checkOutput("ex_rf_dest", 128'(ms_rf_dest), 128'd0);
    waitDrain("ex_drain");

    // Reset in WAIT drops the pending response without counting it.
    sendInstr(3'd0, 1'b1, 1'b0, 32'h0000_0400, 4'b1111, 32'h0, 4'b1111, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    checkOutput("rstwait_ws_valid", 128'(ms_to_ws_valid), 128'd0);
    checkOutput("rstwait_fwd_valid", 128'(ms_fwd_valid), 128'd0);
    checkOutput("rstwait_ex_o", 128'(ms_ex_o), 128'd0);
    checkOutput("rstwait_rf_dest", 128'(ms_rf_dest), 128'd0);
    checkOutput("rstwait_allowin", 128'(ms_allowin), 128'd1);
    reset = 1'b0;
    @(posedge clk); #1;
    sendInstr(3'd0, 1'b1, 1'b0, 32'h0000_0404, 4'b1111, 32'h0BAD_F00D, 4'b1111, 1'b1);
    respond(32'h0BAD_F00D);
    waitDrain("rstwait_drain");

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
